// File: rtl/seed_pattern_gen.sv
// Seed-loaded pattern register that rotates left, rotates right or runs as a
// Fibonacci-style LFSR, stepping once every DIV clocks in the selected mode.
module seed_pattern_gen #(
    parameter int unsigned       WIDTH = 64,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(64'hD800_0000_0000_0000),
    parameter int unsigned       DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             switch1,
    input  logic             switch2,
    output logic [WIDTH-1:0] shift_seed,
    output logic             out1,
    output logic             tick,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_LEFT  = 3'd2,
        S_RIGHT = 3'd3,
        S_LFSR  = 3'd4
    } state_t;

    localparam logic [15:0]      CNT_LAST = 16'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d, mode;
    logic [WIDTH-1:0] pattern_q, pattern_d, step_pattern;
    logic [15:0]      cnt_q, cnt_d;
    logic             out1_q, out1_d, step_out;
    logic             tick_q, tick_d;

    always_comb begin
        unique case ({switch1, switch2})
            2'b10:   mode = S_LEFT;
            2'b01:   mode = S_RIGHT;
            2'b11:   mode = S_LFSR;
            default: mode = S_IDLE;
        endcase
    end

    // Candidate result of a step in the current state; committed only on a count wrap.
    always_comb begin
        step_pattern = pattern_q;
        step_out     = out1_q;
        case (state_q)
            S_LEFT: begin
                step_pattern = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
                step_out     = pattern_q[WIDTH-1];
            end
            S_RIGHT: begin
                step_pattern = {pattern_q[0], pattern_q[WIDTH-1:1]};
                step_out     = pattern_q[0];
            end
            S_LFSR: begin
                if (pattern_q == '0) begin
                    step_pattern = (seed != '0) ? seed : ONE;
                    step_out     = 1'b0;
                end else begin
                    step_pattern = {pattern_q[WIDTH-2:0], ^(pattern_q & TAPS)};
                    step_out     = pattern_q[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = mode;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        out1_d    = out1_q;
        tick_d    = 1'b0;
        if (state_q == S_LOAD) begin
            pattern_d = seed;
            cnt_d     = '0;
        end else if (load) begin
            // Reload wins over both stepping and the mode-change clear.
            pattern_d = seed;
            cnt_d     = '0;
        end else if (mode != state_q || state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            pattern_d = step_pattern;
            out1_d    = step_out;
            cnt_d     = '0;
            tick_d    = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_LOAD;
            pattern_q <= '0;
            cnt_q     <= '0;
            out1_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            out1_q    <= out1_d;
            tick_q    <= tick_d;
        end
    end

    assign shift_seed  = pattern_q;
    assign out1        = out1_q;
    assign tick        = tick_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seed_pattern_gen.sv
// Bench for seed_pattern_gen: a DIV=1 and a DIV=4 instance share stimulus and
// are checked each cycle against a mode/counter model plus directed values.
module tb_seed_pattern_gen;

    localparam int         W     = 8;
    localparam logic [7:0] TP    = 8'hB8;
    localparam int         M_LOAD = 4;   // model-only marker; 0..3 are {switch1,switch2}

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       switch1 = 1'b0;
    logic       switch2 = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] sh1, sh4;
    logic       o1_1, o1_4, t1, t4;
    logic [2:0] st1, st4;

    int checks = 0;
    int failures = 0;

    int         m_div [2];
    int         m_mode[2];
    int         m_cnt [2];
    logic [7:0] m_pat [2];
    logic       m_o1  [2];
    logic       m_tk  [2];

    always #5 clk = ~clk;

    seed_pattern_gen #(.WIDTH(W), .TAPS(TP), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .seed(seed), .load(load),
        .switch1(switch1), .switch2(switch2),
        .shift_seed(sh1), .out1(o1_1), .tick(t1), .dbg_state_o(st1)
    );

    seed_pattern_gen #(.WIDTH(W), .TAPS(TP), .DIV(4)) dut4 (
        .clk(clk), .reset(reset), .seed(seed), .load(load),
        .switch1(switch1), .switch2(switch2),
        .shift_seed(sh4), .out1(o1_4), .tick(t4), .dbg_state_o(st4)
    );

    // Pattern after one step: rotations and LFSR shift by plain arithmetic.
    function automatic logic [7:0] ref_next(input int mode, input logic [7:0] p, input logic [7:0] s);
        int pi;
        pi = int'(p);
        case (mode)
            2: return 8'(((pi * 2) % 256) + (pi / 128));
            1: return 8'((pi / 2) + ((pi % 2) * 128));
            3: begin
                if (pi == 0) return (s != 8'h00) ? s : 8'h01;
                return 8'(((pi * 2) % 256) + ($countones(p & TP) % 2));
            end
            default: return p;
        endcase
    endfunction

    function automatic logic ref_out(input int mode, input logic [7:0] p);
        int pi;
        pi = int'(p);
        case (mode)
            2: return (pi >= 128);
            1: return (pi % 2) == 1;
            3: return (pi >= 128);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_LOAD;
            m_cnt[k]  = 0;
            m_pat[k]  = 8'h00;
            m_o1[k]   = 1'b0;
            m_tk[k]   = 1'b0;
        end
    endtask

    // Effect of the coming rising edge given the inputs now applied.
    task automatic model_edge();
        int want;
        want = int'({switch1, switch2});
        for (int k = 0; k < 2; k++) begin
            m_tk[k] = 1'b0;
            if (m_mode[k] == M_LOAD || load) begin
                m_pat[k] = seed;
                m_cnt[k] = 0;
            end else if (want != m_mode[k] || want == 0) begin
                m_cnt[k] = 0;
            end else if (m_cnt[k] == m_div[k] - 1) begin
                m_o1[k]  = ref_out(m_mode[k], m_pat[k]);
                m_pat[k] = ref_next(m_mode[k], m_pat[k], seed);
                m_cnt[k] = 0;
                m_tk[k]  = 1'b1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
            m_mode[k] = want;
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk8({tag, ".pat1"}, sh1, m_pat[0]);
        chk1({tag, ".out1_1"}, o1_1, m_o1[0]);
        chk1({tag, ".tick1"}, t1, m_tk[0]);
        chk8({tag, ".pat4"}, sh4, m_pat[1]);
        chk1({tag, ".out1_4"}, o1_4, m_o1[1]);
        chk1({tag, ".tick4"}, t4, m_tk[1]);
        // Mode tracking ignores DIV, so both instances must sit in the same state.
        checks++;
        assert (st1 === st4) else begin
            failures++;
            $error("FAIL %s.state observed=%0d expected=%0d", tag, st4, st1);
        end
    endtask

    task automatic cyc(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
            check_all(tag);
        end
    endtask

    // Asserted away from the edge so the clear is visibly asynchronous.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic dir(input string tag, input logic [7:0] p, input logic o, input logic t);
        cyc(1, tag);
        chk8({tag, ".dir_pat"}, sh1, p);
        chk1({tag, ".dir_out1"}, o1_1, o);
        chk1({tag, ".dir_tick"}, t1, t);
    endtask

    initial begin
        m_div[0] = 1;
        m_div[1] = 4;

        // Left rotation
        seed = 8'h81; switch1 = 1'b1; switch2 = 1'b0;
        do_reset("rst_left");
        chk8("rst_pat", sh1, 8'h00);
        chk1("rst_tick", t1, 1'b0);
        dir("left0", 8'h81, 1'b0, 1'b0);
        dir("left1", 8'h03, 1'b1, 1'b1);
        dir("left2", 8'h06, 1'b0, 1'b1);
        dir("left3", 8'h0C, 1'b0, 1'b1);

        // Right rotation
        switch1 = 1'b0; switch2 = 1'b1;
        do_reset("rst_right");
        dir("right0", 8'h81, 1'b0, 1'b0);
        dir("right1", 8'hC0, 1'b1, 1'b1);
        dir("right2", 8'h60, 1'b0, 1'b1);
        dir("right3", 8'h30, 1'b0, 1'b1);

        // LFSR
        switch1 = 1'b1; switch2 = 1'b1;
        do_reset("rst_lfsr");
        dir("lfsr0", 8'h81, 1'b0, 1'b0);
        dir("lfsr1", 8'h03, 1'b1, 1'b1);
        dir("lfsr2", 8'h06, 1'b0, 1'b1);
        dir("lfsr3", 8'h0C, 1'b0, 1'b1);

        // DIV=4: pattern moves on every 4th edge only, then freezes in IDLE
        switch1 = 1'b1; switch2 = 1'b0;
        do_reset("rst_div");
        cyc(4, "div_wait");
        chk8("div4_hold", sh4, 8'h81);
        cyc(1, "div_step");
        chk8("div4_step", sh4, 8'h03);
        chk1("div4_tick", t4, 1'b1);
        cyc(6, "div_run");
        switch1 = 1'b0;
        cyc(8, "div_idle");
        chk8("div4_frozen", sh4, m_pat[1]);
        chk1("div4_idle_tick", t4, 1'b0);

        // LFSR lock-up recovery with zero seed
        seed = 8'h00; switch1 = 1'b1; switch2 = 1'b1;
        do_reset("rst_zero");
        dir("zero0", 8'h00, 1'b0, 1'b0);
        dir("zero1", 8'h01, 1'b0, 1'b1);
        dir("zero2", 8'h02, 1'b0, 1'b1);
        dir("zero3", 8'h04, 1'b0, 1'b1);

        // Mid-run reset, then synchronous reload during LEFT
        seed = 8'h81;
        cyc(3, "pre_rst");
        do_reset("mid_rst");
        chk8("mid_rst_pat", sh1, 8'h00);
        switch2 = 1'b0;
        cyc(3, "post_rst");
        seed = 8'h5A; load = 1'b1;
        dir("reload", 8'h5A, o1_1, 1'b0);
        chk1("reload_tick4", t4, 1'b0);
        load = 1'b0;
        cyc(2, "post_reload");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                switch1 = 1'($urandom_range(0, 1));
                switch2 = 1'($urandom_range(0, 1));
            end
            load = ($urandom_range(0, 15) == 0);
            seed = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            cyc(1, "rnd");
        end
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seed_pattern_gen.md
SEED_PATTERN_GEN -- requirements
Module: seed_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 64, width of seed and pattern register (legal 8..64).
REQ-002 Parameter TAPS, default 64'hD800_0000_0000_0000, LFSR feedback mask, WIDTH bits.
REQ-003 Parameter DIV, default 1, clock cycles per step (legal 1..65535).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 seed  in  WIDTH  value loaded into pattern register.
REQ-007 load  in  1  synchronous seed reload request.
REQ-008 switch1  in  1  mode select MSB.
REQ-009 switch2  in  1  mode select LSB.
REQ-010 shift_seed  out  WIDTH  current pattern register.
REQ-011 out1  out  1  registered copy of bit shifted/rotated out on last step.
REQ-012 tick  out  1  one-cycle pulse, high in cycle after a step commits.

Function
REQ-013 FSM states: LOAD, IDLE, LEFT, RIGHT, LFSR; register-encoded, no other reachable states.
REQ-014 Mode decode of {switch1,switch2}: 00 IDLE, 10 LEFT, 01 RIGHT, 11 LFSR.
REQ-015 LOAD: on first edge after reset release, pattern <= seed, counter <= 0, FSM <= decoded mode; no step that edge.
REQ-016 From IDLE/LEFT/RIGHT/LFSR, FSM <= decoded mode each edge; switch change affects step direction one cycle later.
REQ-017 Mode change (new decoded mode != current state) clears counter to 0; no step on that edge.
REQ-018 Counter: 16-bit, counts 0..DIV-1 in LEFT/RIGHT/LFSR; step occurs on edge where counter == DIV-1, counter wraps to 0.
REQ-019 IDLE: pattern, out1 held; counter held at 0; tick 0.
REQ-020 LEFT step: pattern <= {p[W-2:0], p[W-1]}; out1 <= p[W-1].
REQ-021 RIGHT step: pattern <= {p[0], p[W-1:1]}; out1 <= p[0].
REQ-022 LFSR step: pattern <= {p[W-2:0], ^(p & TAPS)}; out1 <= p[W-1].
REQ-023 LFSR lock-up: step with pattern all-zero loads seed if seed nonzero, else WIDTH'h1; out1 <= 0.
REQ-024 load=1 in any non-LOAD state: pattern <= seed, counter <= 0, no step, tick 0; priority over step and mode-change clear.
REQ-025 tick <= 1 on every committed step (including lock-up recovery), else 0.
REQ-026 DIV=1: step every cycle in active mode.

Reset
REQ-027 reset=1 asynchronously forces FSM=LOAD, shift_seed=0, out1=0, tick=0, counter=0.
REQ-028 reset asserted mid-step or mid-count aborts operation; no partial update survives.
REQ-029 Outputs remain at reset values until LOAD edge completes.

Verification (WIDTH=8, TAPS=8'hB8, DIV=1 unless stated)
REQ-030 Reset, seed=8'h81, switches 10, release -> LOAD edge shift_seed=81; then 03, 06, 0C; out1 1,0,0; tick 1 each cycle.
REQ-031 seed=81, switches 01 -> 81, C0, 60, 30; out1 1,0,0.
REQ-032 seed=81, switches 11 -> 81, 03, 06, 0C; out1 1,0,0 (per REQ-022 parity).
REQ-033 DIV=4, switches 10, seed=81 -> shift_seed changes only every 4th edge; tick period 4; switch to 00 mid-count -> pattern frozen, counter 0.
REQ-034 seed=00, switches 11 -> LOAD gives 00; next step gives 01, tick=1; then 02, 04.
REQ-035 reset pulse mid-run with switches 11, then load=1 with seed=5A during LEFT -> shift_seed=00 immediately on reset; after load edge 5A, no tick that cycle.
